// File: rtl/voice_allocator_if.sv
// Command channel between the CPU note-command MMIO path and voice_allocator.
// The CPU side is the master and drives the command; the allocator is the slave and answers with ready.
interface voice_allocator_if #(
   parameter int NOTE_W = 7,
   parameter int FCW_W  = 24
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_on;
   logic [NOTE_W-1:0] cmd_note;
   logic [FCW_W-1:0]  cmd_fcw;

   modport master (
      output cmd_valid,
      output cmd_on,
      output cmd_note,
      output cmd_fcw,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_on,
      input  cmd_note,
      input  cmd_fcw,
      output cmd_ready
   );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler in the CPU clock domain.
// Takes note-on/note-off commands, assigns notes to carrier voices, keeps the per-voice
// FCW and enable words, and pushes every change to the synth domain over a 4-phase req/ack.
// Optional feature macro: VOICE_STEAL_EN. When defined, a note-on with every voice busy
// steals the oldest voice (per-voice saturating age counters). When undefined, that
// note-on is dropped and neither the age counters nor the steal logic exist.
module voice_allocator #(
   parameter int N_VOICES = 4,
   parameter int NOTE_W   = 7,
   parameter int FCW_W    = 24,
   parameter int AGE_W    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   voice_allocator_if.slave          cmd,
   output logic [FCW_W*N_VOICES-1:0] carrier_fcws,
   output logic [N_VOICES-1:0]       note_en,
   output logic                      cdc_req,
   input  logic                      cdc_ack,
   output logic                      cmd_drop,
   output logic                      steal
);

   localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      ALLOC,
      SYNC,
      REQ,
      RELEASE
   } state_t;

   state_t             state;
   logic               lat_on;
   logic [NOTE_W-1:0]  lat_note;
   logic [FCW_W-1:0]   lat_fcw;
   logic [FCW_W-1:0]   fcw_q  [N_VOICES];
   logic [NOTE_W-1:0]  note_q [N_VOICES];

   logic               hit_found;
   logic [IDX_W-1:0]   hit_idx;
   logic               free_found;
   logic [IDX_W-1:0]   free_idx;
   logic [N_VOICES-1:0] off_mask;

   logic               alloc_do;
   logic [IDX_W-1:0]   alloc_idx;
   logic               off_do;

`ifdef VOICE_STEAL_EN
   logic [AGE_W-1:0]   age_q [N_VOICES];
   logic [IDX_W-1:0]   old_idx;
   logic [AGE_W-1:0]   old_age;
   logic               alloc_steal;
   logic               steal_q;

   // Oldest active voice; strict compare keeps the lowest index on ties
   always_comb begin
      old_idx = '0;
      old_age = age_q[0];
      for (int v = 1; v < N_VOICES; v++) begin
         if (age_q[v] > old_age) begin
            old_age = age_q[v];
            old_idx = IDX_W'(v);
         end
      end
   end

   assign steal = steal_q;
`else
   assign steal = 1'b0;
`endif

   assign cmd.cmd_ready = (state == IDLE);

   // Scan voices for a matching active note, the lowest free voice and the note-off mask
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      off_mask   = '0;
      for (int v = N_VOICES - 1; v >= 0; v--) begin
         if (note_en[v] && (note_q[v] == lat_note)) begin
            hit_found   = 1'b1;
            hit_idx     = IDX_W'(v);
            off_mask[v] = 1'b1;
         end
         if (!note_en[v]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(v);
         end
      end
   end

   // Allocation decision: retrigger beats a free voice, which beats stealing
   always_comb begin
      alloc_do  = 1'b0;
      alloc_idx = '0;
`ifdef VOICE_STEAL_EN
      alloc_steal = 1'b0;
`endif
      if (lat_on) begin
         if (hit_found) begin
            alloc_do  = 1'b1;
            alloc_idx = hit_idx;
         end else if (free_found) begin
            alloc_do  = 1'b1;
            alloc_idx = free_idx;
         end
`ifdef VOICE_STEAL_EN
         else begin
            alloc_do    = 1'b1;
            alloc_idx   = old_idx;
            alloc_steal = 1'b1;
         end
`endif
      end
      off_do = !lat_on && (|off_mask);
   end

   // Pack the per-voice FCW registers onto the flat output bus
   always_comb begin
      carrier_fcws = '0;
      for (int v = 0; v < N_VOICES; v++) begin
         carrier_fcws[FCW_W*v +: FCW_W] = fcw_q[v];
      end
   end

   // Control FSM, command latch, voice table and the req/ack handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         lat_on   <= 1'b0;
         lat_note <= '0;
         lat_fcw  <= '0;
         note_en  <= '0;
         cdc_req  <= 1'b0;
         cmd_drop <= 1'b0;
         for (int v = 0; v < N_VOICES; v++) begin
            fcw_q[v]  <= '0;
            note_q[v] <= '0;
`ifdef VOICE_STEAL_EN
            age_q[v]  <= '0;
`endif
         end
`ifdef VOICE_STEAL_EN
         steal_q <= 1'b0;
`endif
      end else begin
         cmd_drop <= 1'b0;
`ifdef VOICE_STEAL_EN
         steal_q  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (cmd.cmd_valid) begin
                  lat_on   <= cmd.cmd_on;
                  lat_note <= cmd.cmd_note;
                  lat_fcw  <= cmd.cmd_fcw;
                  state    <= ALLOC;
               end
            end
            ALLOC: begin
               if (alloc_do) begin
                  for (int v = 0; v < N_VOICES; v++) begin
                     if (alloc_idx == IDX_W'(v)) begin
                        note_en[v] <= 1'b1;
                        fcw_q[v]   <= lat_fcw;
                        note_q[v]  <= lat_note;
`ifdef VOICE_STEAL_EN
                        age_q[v]   <= '0;
                     end else if (note_en[v] && (age_q[v] != {AGE_W{1'b1}})) begin
                        age_q[v]   <= age_q[v] + AGE_W'(1);
`endif
                     end
                  end
`ifdef VOICE_STEAL_EN
                  steal_q <= alloc_steal;
`endif
                  state <= SYNC;
               end else if (off_do) begin
                  note_en <= note_en & ~off_mask;
                  state   <= SYNC;
               end else begin
                  cmd_drop <= 1'b1;
                  state    <= IDLE;
               end
            end
            SYNC: begin
               if (!cdc_ack) begin
                  cdc_req <= 1'b1;
                  state   <= REQ;
               end
            end
            REQ: begin
               if (cdc_ack) begin
                  cdc_req <= 1'b0;
                  state   <= RELEASE;
               end
            end
            RELEASE: begin
               if (!cdc_ack) begin
                  state <= IDLE;
               end
            end
            default: begin
               cdc_req <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed testbench for voice_allocator: reset state, allocation, stealing or dropping,
// note-off, retrigger and reset in the middle of a handshake.
module tb_voice_allocator;

   localparam int N_VOICES = 4;
   localparam int NOTE_W   = 7;
   localparam int FCW_W    = 24;
   localparam int AGE_W    = 4;

   logic                      clk;
   logic                      rst_n;
   logic [FCW_W*N_VOICES-1:0] carrier_fcws;
   logic [N_VOICES-1:0]       note_en;
   logic                      cdc_req;
   logic                      cdc_ack;
   logic                      cmd_drop;
   logic                      steal;

   int checks;
   int errors;

   voice_allocator_if #(.NOTE_W(NOTE_W), .FCW_W(FCW_W)) cmd_bus ();

   voice_allocator #(
      .N_VOICES (N_VOICES),
      .NOTE_W   (NOTE_W),
      .FCW_W    (FCW_W),
      .AGE_W    (AGE_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd          (cmd_bus.slave),
      .carrier_fcws (carrier_fcws),
      .note_en      (note_en),
      .cdc_req      (cdc_req),
      .cdc_ack      (cdc_ack),
      .cmd_drop     (cmd_drop),
      .steal        (steal)
   );

   // Free-running CPU clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Count one comparison and report it if it does not match
   task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [FCW_W-1:0] fcwOf(input int v);
      return carrier_fcws[FCW_W*v +: FCW_W];
   endfunction

   // Issue one command from IDLE and walk it through ALLOC and, if it changes anything,
   // the full 4-phase handshake with an immediately answering cdc model
   task automatic applyStimulus(input logic on, input logic [NOTE_W-1:0] note, input logic [FCW_W-1:0] fcw,
                                input logic exp_change, input logic exp_steal, input string tag);
      checkOutput({tag, "_ready"}, cmd_bus.cmd_ready, 1);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_on    = on;
      cmd_bus.cmd_note  = note;
      cmd_bus.cmd_fcw   = fcw;
      @(posedge clk); #1;
      cmd_bus.cmd_valid = 1'b0;
      checkOutput({tag, "_alloc_req"}, cdc_req, 0);
      @(posedge clk); #1;
      checkOutput({tag, "_drop"}, cmd_drop, !exp_change);
      checkOutput({tag, "_steal"}, steal, exp_steal);
      checkOutput({tag, "_sync_req"}, cdc_req, 0);
      if (exp_change) begin
         @(posedge clk); #1;
         checkOutput({tag, "_req_rise"}, cdc_req, 1);
         cdc_ack = 1'b1;
         @(posedge clk); #1;
         checkOutput({tag, "_req_fall"}, cdc_req, 0);
         cdc_ack = 1'b0;
         @(posedge clk); #1;
      end
      checkOutput({tag, "_done_ready"}, cmd_bus.cmd_ready, 1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      cdc_ack = 1'b0;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_on    = 1'b0;
      cmd_bus.cmd_note  = '0;
      cmd_bus.cmd_fcw   = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_note_en", note_en, 0);
      checkOutput("rst_fcws", carrier_fcws, 0);
      checkOutput("rst_req", cdc_req, 0);
      checkOutput("rst_drop", cmd_drop, 0);
      checkOutput("rst_steal", steal, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst_ready", cmd_bus.cmd_ready, 1);

      // Fill all four voices
      applyStimulus(1'b1, 7'd60, 24'h0123AB, 1'b1, 1'b0, "on60");
      checkOutput("on60_en", note_en, 4'b0001);
      checkOutput("on60_fcw0", fcwOf(0), 24'h0123AB);
      applyStimulus(1'b1, 7'd62, 24'h111111, 1'b1, 1'b0, "on62");
      applyStimulus(1'b1, 7'd64, 24'h222222, 1'b1, 1'b0, "on64");
      applyStimulus(1'b1, 7'd65, 24'h333333, 1'b1, 1'b0, "on65");
      checkOutput("full_en", note_en, 4'b1111);
      checkOutput("full_fcw3", fcwOf(3), 24'h333333);

      // All voices busy: voice 0 is the oldest
`ifdef VOICE_STEAL_EN
      applyStimulus(1'b1, 7'd67, 24'h777777, 1'b1, 1'b1, "on67_steal");
      checkOutput("on67_fcw0", fcwOf(0), 24'h777777);
`else
      applyStimulus(1'b1, 7'd67, 24'h777777, 1'b0, 1'b0, "on67_drop");
      checkOutput("on67_fcw0", fcwOf(0), 24'h0123AB);
`endif
      checkOutput("on67_en", note_en, 4'b1111);

      // Note-off with a match, then one without
      applyStimulus(1'b0, 7'd62, 24'h0, 1'b1, 1'b0, "off62");
      checkOutput("off62_en", note_en, 4'b1101);
      checkOutput("off62_fcw1", fcwOf(1), 24'h111111);
      applyStimulus(1'b0, 7'd99, 24'h0, 1'b0, 1'b0, "off99");
      checkOutput("off99_en", note_en, 4'b1101);

      // New note takes the freed voice, then retriggers while every voice is busy
      applyStimulus(1'b1, 7'd70, 24'hAAAAAA, 1'b1, 1'b0, "on70a");
      checkOutput("on70a_en", note_en, 4'b1111);
      checkOutput("on70a_fcw1", fcwOf(1), 24'hAAAAAA);
      applyStimulus(1'b1, 7'd70, 24'hBBBBBB, 1'b1, 1'b0, "on70b");
      checkOutput("on70b_en", note_en, 4'b1111);
      checkOutput("on70b_fcw1", fcwOf(1), 24'hBBBBBB);
      checkOutput("on70b_fcw2", fcwOf(2), 24'h222222);

      // Ages now: v0=2, v1=0, v2=4, v3=3 in the steal build, so voice 2 is oldest
`ifdef VOICE_STEAL_EN
      applyStimulus(1'b1, 7'd80, 24'h888888, 1'b1, 1'b1, "on80_steal");
      checkOutput("on80_fcw2", fcwOf(2), 24'h888888);
      checkOutput("on80_fcw0", fcwOf(0), 24'h777777);
`else
      applyStimulus(1'b1, 7'd80, 24'h888888, 1'b0, 1'b0, "on80_drop");
      checkOutput("on80_fcw2", fcwOf(2), 24'h222222);
      checkOutput("on80_fcw0", fcwOf(0), 24'h0123AB);
`endif

      // Reset in the middle of REQ with ack held high
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_on    = 1'b0;
      cmd_bus.cmd_note  = 7'd65;
      cmd_bus.cmd_fcw   = '0;
      @(posedge clk); #1;
      cmd_bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("midrst_req_up", cdc_req, 1);
      cdc_ack = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_req_drop", cdc_req, 0);
      checkOutput("midrst_en", note_en, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Next command must wait in SYNC while ack is still high
      checkOutput("sync_ready", cmd_bus.cmd_ready, 1);
      cmd_bus.cmd_valid = 1'b1;
      cmd_bus.cmd_on    = 1'b1;
      cmd_bus.cmd_note  = 7'd50;
      cmd_bus.cmd_fcw   = 24'h0A0A0A;
      @(posedge clk); #1;
      cmd_bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("sync_drop", cmd_drop, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("sync_wait_req", cdc_req, 0);
      end
      cdc_ack = 1'b0;
      @(posedge clk); #1;
      checkOutput("sync_req_rise", cdc_req, 1);
      cdc_ack = 1'b1;
      @(posedge clk); #1;
      checkOutput("sync_req_fall", cdc_req, 0);
      cdc_ack = 1'b0;
      @(posedge clk); #1;
      checkOutput("sync_done_ready", cmd_bus.cmd_ready, 1);
      checkOutput("sync_en", note_en, 4'b0001);
      checkOutput("sync_fcw0", fcwOf(0), 24'h0A0A0A);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
